// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: sends a header and then `len` x/w operand beats to one PE, and captures the PE result.
// Optional WAIT_DONE watchdog is built when FEEDER_TIMEOUT_EN is defined.
module pe_stream_feeder #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 10,
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 784,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] x_rdata,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              head,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] w_out,
  input  logic              pe_done,
  input  logic [DATA_W-1:0] pe_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              err_len,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, HEADER, STREAM, WAIT_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] beats_left;
  logic [CNT_W-1:0] reads_left;
  logic             len_ok;

  assign len_ok = (len != '0) && (len <= CNT_W'(MAX_LEN));

`ifdef FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beats_left   <= '0;
      reads_left   <= '0;
      head         <= 1'b0;
      x_out        <= '0;
      w_out        <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err_len      <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      wd_cnt       <= '0;
      err_timeout  <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      err_len      <= 1'b0;

      // Reads run one cycle ahead of the beats; the first one is issued on the accept edge.
      if (state == HEADER || state == STREAM) begin
        rd_en <= (reads_left != '0);
        if (reads_left != '0) begin
          rd_addr    <= rd_addr + ADDR_W'(1);
          reads_left <= reads_left - CNT_W'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state      <= HEADER;
              busy       <= 1'b1;
              beats_left <= len;
              reads_left <= len - CNT_W'(1);
              rd_en      <= 1'b1;
              rd_addr    <= base_addr;
`ifdef FEEDER_TIMEOUT_EN
              wd_cnt      <= '0;
              err_timeout <= 1'b0;
`endif
            end else begin
              err_len <= 1'b1;
            end
          end
        end

        HEADER: begin
          head  <= 1'b1;
          x_out <= DATA_W'(beats_left);
          w_out <= '0;
          state <= STREAM;
        end

        STREAM: begin
          head  <= 1'b0;
          x_out <= x_rdata;
          w_out <= w_rdata;
          if (beats_left == CNT_W'(1)) begin
            state <= WAIT_DONE;
          end else begin
            beats_left <= beats_left - CNT_W'(1);
          end
        end

        WAIT_DONE: begin
          x_out <= '0;
          w_out <= '0;
          if (pe_done) begin
            result       <= pe_result;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Self-checking bench for pe_stream_feeder: table of jobs, scoreboard of expected beats and results.
// Define FEEDER_TIMEOUT_EN for both files to exercise the watchdog (TIMEOUT is overridden to 16).
module tb_pe_stream_feeder;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  len;
  logic [9:0]  base_addr;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] x_rdata = '0;
  logic [31:0] w_rdata = '0;
  logic        head;
  logic [31:0] x_out;
  logic [31:0] w_out;
  logic        pe_done;
  logic [31:0] pe_result;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        err_len;
  logic        err_timeout;

  pe_stream_feeder #(
    .DATA_W(32), .CNT_W(10), .ADDR_W(10), .MAX_LEN(784), .TIMEOUT(16)
  ) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .len(len), .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .x_rdata(x_rdata), .w_rdata(w_rdata),
    .head(head), .x_out(x_out), .w_out(w_out), .pe_done(pe_done), .pe_result(pe_result),
    .result(result), .result_valid(result_valid), .busy(busy), .err_len(err_len),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          len;
    int          base;
    bit          fill;      // constant operand pattern instead of x[a]=a
    logic [31:0] res;       // PE result to return
    bit          exp_err;   // expected to be rejected
    int          pe_delay;  // extra WAIT_DONE cycles before pe_done
    bit          spur;      // inject pe_done and start during beat 3
  } job_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] w;
  } beat_t;

  logic [31:0] x_mem [1024];
  logic [31:0] w_mem [1024];
  beat_t       beat_q [$];
  logic [31:0] res_q  [$];
  job_t        jobs   [8];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc, head_cyc, first_cyc, last_cyc;
  int rd_cycles, head_count, rv_count, beats_rem, beat_idx;
  int exp_len;
  bit beats_done;
  logic [31:0] last_res = '0;

  // Sync-read operand memories, one cycle latency.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      x_rdata <= x_mem[rd_addr];
      w_rdata <= w_mem[rd_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor on the falling edge: header, beats and results against the scoreboard.
  always @(negedge clock) begin : mon
    beat_t b;
    if (!rst_n) begin
      beats_rem = 0;
      beat_q.delete();
    end else begin
      if (rd_en) rd_cycles++;
      if (result_valid) begin
        rv_count++;
        if (res_q.size() == 0) check("result_valid_unexpected", 1, 0);
        else check("result", result, res_q.pop_front());
      end
      if (head) begin
        head_count++;
        head_cyc = cyc;
        check("hdr_x", x_out, 32'(exp_len));
        check("hdr_w", w_out, 32'h0);
        beats_rem = int'(x_out);
        beat_idx  = 0;
      end else if (beats_rem > 0) begin
        if (beat_idx == 0) first_cyc = cyc;
        if (beat_q.size() == 0) begin
          check("beat_extra", 1, 0);
        end else begin
          b = beat_q.pop_front();
          check("beat_x", x_out, b.x);
          check("beat_w", w_out, b.w);
        end
        check("busy_in_beat", {31'b0, busy}, 32'h1);
        beat_idx++;
        beats_rem--;
        if (beats_rem == 0) begin
          last_cyc   = cyc;
          beats_done = 1'b1;
        end
      end
    end
  end

  task automatic push_expected(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % 1024;
      beat_q.push_back('{x: x_mem[a], w: w_mem[a]});
    end
  endtask

  task automatic kick(input int l, input int b);
    @(posedge clock); #1;
    start = 1'b1;
    len = 10'(l);
    base_addr = 10'(b);
    @(posedge clock); #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_beats(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (beats_done) break;
      @(negedge clock); #1;
    end
    check("beats_done_in_time", {31'b0, beats_done}, 32'h1);
  endtask

  task automatic run_job(input job_t j);
    int rv0;
    exp_len = j.len;
    beats_done = 1'b0;
    rd_cycles = 0;
    head_count = 0;
    rv0 = rv_count;
    if (!j.exp_err) begin
      push_expected(j.base, j.len);
      res_q.push_back(j.res);
    end
    kick(j.len, j.base);
    if (j.exp_err) begin
      check("rej_err_len", {31'b0, err_len}, 32'h1);
      check("rej_busy", {31'b0, busy}, 32'h0);
      check("rej_rd_en", {31'b0, rd_en}, 32'h0);
      @(posedge clock); #1;
      check("rej_err_pulse", {31'b0, err_len}, 32'h0);
      check("rej_no_reads", 32'(rd_cycles), 32'h0);
      return;
    end
    check("acc_busy", {31'b0, busy}, 32'h1);
    check("acc_rd_en", {31'b0, rd_en}, 32'h1);
    check("acc_rd_addr", {22'b0, rd_addr}, 32'(j.base));
    check("acc_err_timeout_clear", {31'b0, err_timeout}, 32'h0);
    if (j.spur) begin
      repeat (5) @(posedge clock);
      #1;
      pe_done = 1'b1;
      pe_result = 32'hBADBAD00;
      start = 1'b1;
      len = 10'd3;
      base_addr = 10'd50;
      @(posedge clock); #1;
      pe_done = 1'b0;
      pe_result = '1;
      start = 1'b0;
      check("spur_no_err_len", {31'b0, err_len}, 32'h0);
      check("spur_still_busy", {31'b0, busy}, 32'h1);
    end
    wait_beats(j.len + 30);
    if (!beats_done) return;
    repeat (j.pe_delay) @(posedge clock);
    if (j.pe_delay > 0) begin
      #1;
      check("wait_busy", {31'b0, busy}, 32'h1);
      check("wait_no_timeout", {31'b0, err_timeout}, 32'h0);
    end
    @(posedge clock); #1;
    pe_done = 1'b1;
    pe_result = j.res;
    @(posedge clock); #1;
    pe_done = 1'b0;
    pe_result = '1;
    last_res = j.res;
    check("done_result_valid", {31'b0, result_valid}, 32'h1);
    check("done_result", result, j.res);
    check("done_busy_low", {31'b0, busy}, 32'h0);
    check("done_x_zero", x_out, 32'h0);
    @(posedge clock); #1;
    check("result_valid_pulse", {31'b0, result_valid}, 32'h0);
    check("head_count", 32'(head_count), 32'h1);
    check("rd_cycles", 32'(rd_cycles), 32'(j.len));
    check("lat_head", 32'(head_cyc - acc_cyc), 32'h1);
    check("lat_beat0", 32'(first_cyc - acc_cyc), 32'h2);
    check("lat_last", 32'(last_cyc - acc_cyc), 32'(j.len + 1));
    check("rv_count", 32'(rv_count - rv0), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int rv0, k;
    for (int a = 0; a < 1024; a++) begin
      x_mem[a] = 32'(a);
      w_mem[a] = 32'h8000_0000 | 32'(a);
    end
    rv_count = 0;
    beats_rem = 0;
    start = 1'b0;
    len = '0;
    base_addr = '0;
    pe_done = 1'b0;
    pe_result = '1;
    rst_n = 1'b0;

    jobs[0] = '{len: 9,   base: 0,    fill: 1'b1, res: 32'h4008_0000, exp_err: 1'b0, pe_delay: 0, spur: 1'b0};
    jobs[1] = '{len: 6,   base: 1020, fill: 1'b0, res: 32'h3F80_0000, exp_err: 1'b0, pe_delay: 2, spur: 1'b0};
    jobs[2] = '{len: 0,   base: 5,    fill: 1'b0, res: 32'h0,         exp_err: 1'b1, pe_delay: 0, spur: 1'b0};
    jobs[3] = '{len: 785, base: 5,    fill: 1'b0, res: 32'h0,         exp_err: 1'b1, pe_delay: 0, spur: 1'b0};
    jobs[4] = '{len: 1,   base: 7,    fill: 1'b0, res: 32'h1234_5678, exp_err: 1'b0, pe_delay: 0, spur: 1'b0};
    jobs[5] = '{len: 784, base: 200,  fill: 1'b0, res: 32'hDEAD_BEEF, exp_err: 1'b0, pe_delay: 1, spur: 1'b0};
    jobs[6] = '{len: 2,   base: 1023, fill: 1'b0, res: 32'h0000_0001, exp_err: 1'b0, pe_delay: 0, spur: 1'b0};
    jobs[7] = '{len: 9,   base: 0,    fill: 1'b1, res: 32'h4110_0000, exp_err: 1'b0, pe_delay: 0, spur: 1'b1};

    #12;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_head", {31'b0, head}, 32'h0);
    check("rst_rd_en", {31'b0, rd_en}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_err_timeout", {31'b0, err_timeout}, 32'h0);
    rst_n = 1'b1;

    foreach (jobs[n]) begin
      if (!jobs[n].exp_err) begin
        for (int i = 0; i < jobs[n].len; i++) begin
          int a;
          a = (jobs[n].base + i) % 1024;
          x_mem[a] = jobs[n].fill ? 32'h3E80_0000 : 32'(a);
          w_mem[a] = jobs[n].fill ? 32'h3F00_0000 : (32'h8000_0000 | 32'(a));
        end
      end
      run_job(jobs[n]);
    end

    // Reset during beat 4 abandons the job without a result.
    exp_len = 9;
    beats_done = 1'b0;
    push_expected(300, 9);
    rv0 = rv_count;
    kick(9, 300);
    repeat (6) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_x_out", x_out, 32'h0);
    check("mid_rst_w_out", w_out, 32'h0);
    check("mid_rst_rd_en", {31'b0, rd_en}, 32'h0);
    check("mid_rst_rd_addr", {22'b0, rd_addr}, 32'h0);
    check("mid_rst_result", result, 32'h0);
    @(posedge clock); #3;
    rst_n = 1'b1;
    beat_q.delete();
    repeat (3) @(posedge clock);
    #1;
    check("mid_rst_no_result", 32'(rv_count - rv0), 32'h0);
    run_job('{len: 1, base: 900, fill: 1'b0, res: 32'h3C00_0000, exp_err: 1'b0, pe_delay: 0, spur: 1'b0});

`ifdef FEEDER_TIMEOUT_EN
    // pe_done never arrives: watchdog fires 16 cycles into WAIT_DONE.
    exp_len = 2;
    beats_done = 1'b0;
    push_expected(10, 2);
    rv0 = rv_count;
    kick(2, 10);
    wait_beats(40);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (err_timeout) begin
        k = c;
        break;
      end
    end
    check("timeout_cycles", 32'(k), 32'd16);
    check("timeout_busy", {31'b0, busy}, 32'h0);
    check("timeout_result_kept", result, last_res);
    repeat (3) @(posedge clock);
    #1;
    check("timeout_sticky", {31'b0, err_timeout}, 32'h1);
    check("timeout_no_result", 32'(rv_count - rv0), 32'h0);
`else
    // Without the watchdog the feeder waits as long as the PE takes.
    run_job('{len: 3, base: 40, fill: 1'b0, res: 32'h4040_0000, exp_err: 1'b0, pe_delay: 40, spur: 1'b0});
`endif
    run_job('{len: 4, base: 60, fill: 1'b0, res: 32'h4080_0000, exp_err: 1'b0, pe_delay: 0, spur: 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
